// File: rtl/sensor_array_ctl_pkg.sv
// Shared types and field positions for the multi-channel sensor controller:
// FSM state encoding, command/result word layout and a result packing helper.
package sensor_array_ctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_SCAN  = 3'd3,
        ST_REQ   = 3'd4,
        ST_WAIT  = 3'd5,
        ST_PUSH  = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    localparam int CMD_CONT_BIT = 30;
    localparam int RES_ERR_BIT  = 31;
    localparam int RES_IDX_LSB  = 24;
    localparam int RES_IDX_W    = 7;
    localparam int RES_MEAS_W   = 24;

    function automatic logic [31:0] pack_result(input logic err,
                                                input logic [RES_IDX_W-1:0] idx,
                                                input logic [RES_MEAS_W-1:0] meas);
        return {err, idx, meas};
    endfunction

endpackage

// File: rtl/sensor_array_ctl_ch_sel.sv
// Channel selector: combinational pick of the lowest set mask bit at or above
// the current index, plus the registered channel index itself.
module sensor_array_ctl_ch_sel #(
    parameter int CH = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] mask,
    input  logic          clr,
    input  logic          load,
    output logic [IW-1:0] idx,
    output logic [IW-1:0] pick,
    output logic          found
);

    // Walking downwards lets the lowest qualifying bit win.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (mask[i] && (IW'(i) >= idx)) begin
                found = 1'b1;
                pick  = IW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx <= '0;
        end else if (load) begin
            idx <= pick;
        end
    end

endmodule

// File: rtl/sensor_array_ctl.sv
// Pops channel-mask commands, triggers sensors one at a time in ascending order
// and pushes one tagged result per channel. SENSOR_TIMEOUT_EN adds a WAIT timeout.
module sensor_array_ctl
    import sensor_array_ctl_pkg::*;
#(
    parameter int CH      = 4,
    parameter int DW      = 32,
    parameter int SW      = 32,
    parameter int TIMEOUT = 2**22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    cmd_data,
    input  logic             cmd_empty,
    output logic             cmd_rd_en,
    output logic [DW-1:0]    res_data,
    input  logic             res_full,
    output logic             res_wr_en,
    output logic [CH-1:0]    sns_req,
    input  logic [CH-1:0]    sns_busy,
    input  logic [CH-1:0]    sns_finish,
    input  logic [CH*SW-1:0] sns_data,
    output logic             busy,
    output state_t           state_dbg
);

    // Handshakes: cmd_rd_en pops one word whose data is valid the next cycle;
    // res_wr_en pushes res_data only while res_full is low; sns_req is a
    // single-cycle one-hot pulse answered by sns_finish with sns_busy low.

    localparam int IW = (CH > 1) ? $clog2(CH) : 1;

    state_t          state_q, state_d;
    logic [CH-1:0]   mask_q, saved_q;
    logic            cont_q;
    logic [DW-1:0]   res_q;
    logic [IW-1:0]   idx, pick;
    logic            found, sel_clr, sel_load;
    logic [SW-1:0]   meas_raw;
    logic [SW+23:0]  meas_ext;
    logic            finish_hit, timeout_hit;
    logic            unused_bits;

    sensor_array_ctl_ch_sel #(.CH(CH), .IW(IW)) u_ch_sel (
        .clk   (clk),
        .rst   (rst),
        .mask  (mask_q),
        .clr   (sel_clr),
        .load  (sel_load),
        .idx   (idx),
        .pick  (pick),
        .found (found)
    );

    assign meas_raw   = sns_data[int'(idx)*SW +: SW];
    assign meas_ext   = {24'b0, meas_raw};
    assign finish_hit = sns_finish[idx] && !sns_busy[idx];

`ifdef SENSOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    // Counter is zeroed in REQ so the timeout fires TIMEOUT cycles after it.
    always_ff @(posedge clk) begin
        if (rst || state_q == ST_REQ) begin
            tmo_cnt <= '0;
        end else if (state_q == ST_WAIT) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign timeout_hit = (state_q == ST_WAIT) && (tmo_cnt == TW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cmd_rd_en = 1'b0;
        res_wr_en = 1'b0;
        sns_req   = '0;
        sel_clr   = 1'b0;
        sel_load  = 1'b0;
        case (state_q)
            ST_IDLE:  if (!cmd_empty) state_d = ST_FETCH;
            ST_FETCH: begin
                cmd_rd_en = 1'b1;
                state_d   = ST_LATCH;
            end
            ST_LATCH: begin
                sel_clr = 1'b1;
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (found) begin
                    sel_load = 1'b1;
                    state_d  = ST_REQ;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_REQ: begin
                sns_req = CH'(1) << idx;
                state_d = ST_WAIT;
            end
            ST_WAIT:  if (finish_hit || timeout_hit) state_d = ST_PUSH;
            ST_PUSH: begin
                if (!res_full) begin
                    res_wr_en = 1'b1;
                    state_d   = ST_SCAN;
                end
            end
            ST_DONE: begin
                if (cont_q && cmd_empty) begin
                    sel_clr = 1'b1;
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            saved_q <= '0;
            cont_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_LATCH: begin
                    mask_q  <= cmd_data[CH-1:0];
                    saved_q <= cmd_data[CH-1:0];
                    // An empty mask never loops, whatever the continuous bit says.
                    cont_q  <= cmd_data[CMD_CONT_BIT] && (|cmd_data[CH-1:0]);
                end
                ST_WAIT: begin
                    if (finish_hit) begin
                        res_q <= DW'(pack_result(1'b0, RES_IDX_W'(idx), meas_ext[RES_MEAS_W-1:0]));
                    end else if (timeout_hit) begin
                        res_q <= DW'(pack_result(1'b1, RES_IDX_W'(idx), '0));
                    end
                end
                ST_PUSH: if (!res_full) mask_q[idx] <= 1'b0;
                ST_DONE: if (cont_q && cmd_empty) mask_q <= saved_q;
                default: ;
            endcase
        end
    end

    assign res_data  = res_q;
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

    assign unused_bits = ^{cmd_data[DW-1:RES_ERR_BIT], cmd_data[CMD_CONT_BIT-1:CH],
                           meas_ext[SW+23:RES_MEAS_W], TIMEOUT};

endmodule
